ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit for the npc core. It owns the fetch PC and issues one aligned memory read at a time over a valid/ready request port. It buffers fetched {pc, inst} pairs in a DEPTH-entry queue and hands them to decode over a valid/ready port. It also accepts redirects (taken branch/jump) that flush all in-flight and buffered fetches. It replaces the fixed single-cycle fetch, in which the PC register read memory combinationally.

---
 rtl/ifu_prefetch.sv | 149 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit for the npc core. It issues one read at a time and buffers {pc, inst} pairs for decode.
// Define IFU_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifu_prefetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [63:0]     mem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [31:0]     r_q_inst [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_redirect_pc;
    logic [31:0]     w_resp_word;
    logic            w_resp_live;
    logic            w_q_valid;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;
    logic            w_issue_after;
    logic            w_unused_redirect_lsb;

    assign w_redirect_pc         = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
    assign w_resp_word           = r_fetch_pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    // A response in WAIT is only useful if no redirect arrives in the same cycle.
    assign w_resp_live = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;
    assign w_q_valid   = (r_count != '0);

`ifdef IFU_BYPASS_EN
    assign w_bypass = w_resp_live && !w_q_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign inst_valid = w_q_valid || w_bypass;
    assign inst_pc    = w_bypass ? r_fetch_pc  : r_q_pc[r_rd_ptr];
    assign inst       = w_bypass ? w_resp_word : r_q_inst[r_rd_ptr];

    assign w_pop  = w_q_valid && inst_ready;
    assign w_push = w_resp_live && !(w_bypass && inst_ready);

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = {r_fetch_pc[XLEN-1:3], 3'b000};

    always_comb begin
        w_count_next = r_count;
        if (redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // The reserved slot for the next response is judged on the post-update occupancy.
    assign w_issue_after = !halt && (w_count_next < CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
            end
        end else begin
            r_count <= w_count_next;

            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_wr_ptr]   <= r_fetch_pc;
                    r_q_inst[r_wr_ptr] <= w_resp_word;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_resp_live) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end

            // A redirect while a request is in flight makes its response stale.
            case (r_state)
                S_IDLE: begin
                    if (!halt && (r_count < CW'(DEPTH))) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= redirect_valid ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT, S_DISCARD: begin
                    if (mem_resp_valid) begin
                        r_state <= w_issue_after ? S_REQ : S_IDLE;
                    end else if (redirect_valid) begin
                        r_state <= S_DISCARD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: cycle tables and directed corner cases, then a randomized run
// checked against an instruction-stream model (expected PC sequence and a memory content function).
module tb_ifu_prefetch;

    localparam int          XLEN  = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] B     = 64'h0000_0000_8000_0000;
`ifdef IFU_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [63:0]     mem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [31:0]     inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;

    int checkCount = 0;
    int passCount  = 0;

    ifu_prefetch #(
        .XLEN    (XLEN),
        .RESET_PC(B),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [63:0] raddr;
        logic        irdy;
        logic        expRv;
        logic [63:0] expAddr;
        logic        expIv;
        logic [63:0] expIpc;
    } vec_t;

    // Memory contents are a fixed function of the doubleword address.
    function automatic logic [63:0] memWord(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] + 32'h1357_9BDF};
    endfunction

    function automatic logic [31:0] instAt(input logic [63:0] pc);
        logic [63:0] d;
        d = memWord({pc[63:3], 3'b000});
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [63:0] raddr,
                                input logic irdy, input logic erv, input logic [63:0] eaddr,
                                input logic eiv, input logic [63:0] eipc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.raddr = raddr; v.irdy = irdy;
        v.expRv = erv; v.expAddr = eaddr; v.expIv = eiv; v.expIpc = eipc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic rdy, input logic rsp, input logic [63:0] raddr,
                                 input logic irdy, input logic hlt, input logic rdv,
                                 input logic [63:0] rpc);
        @(posedge clk);
        #1;
        mem_req_ready  = rdy;
        mem_resp_valid = rsp;
        mem_resp_data  = rsp ? memWord(raddr) : 64'h0;
        inst_ready     = irdy;
        halt           = hlt;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic acceptCycle();
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic doReset();
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'h0;
        inst_ready     = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    vec_t        tbl [18];
    logic        pend;
    int          pdelay;
    logic [63:0] paddr;
    logic [63:0] expPc;
    logic        prevRv;
    logic        prevHalt;
    logic        hlt;
    logic        rspNow;
    int          delivered;

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, B,      1'b0, 64'h0);
        tbl[1]  = mk(1'b1, 1'b1, B,      1'b0, 1'b0, B,      BYP,  B);
        tbl[2]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, B,      1'b1, B);
        tbl[3]  = mk(1'b1, 1'b1, B,      1'b0, 1'b0, B,      1'b1, B);
        tbl[4]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, B+8,    1'b1, B);
        tbl[5]  = mk(1'b1, 1'b1, B+8,    1'b0, 1'b0, B+8,    1'b1, B);
        tbl[6]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, B+8,    1'b1, B);
        tbl[7]  = mk(1'b1, 1'b1, B+8,    1'b0, 1'b0, B+8,    1'b1, B);
        tbl[8]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, B+16,   1'b1, B);
        tbl[9]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b0, B+16,   1'b1, B);
        tbl[10] = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, B+16,   1'b1, B);
        tbl[11] = mk(1'b1, 1'b0, 64'h0,  1'b1, 1'b0, B+16,   1'b1, B+4);
        tbl[12] = mk(1'b1, 1'b0, 64'h0,  1'b0, 1'b1, B+16,   1'b1, B+8);
        tbl[13] = mk(1'b1, 1'b1, B+16,   1'b0, 1'b0, B+16,   1'b1, B+8);
        tbl[14] = mk(1'b0, 1'b0, 64'h0,  1'b1, 1'b1, B+16,   1'b1, B+8);
        tbl[15] = mk(1'b0, 1'b0, 64'h0,  1'b1, 1'b1, B+16,   1'b1, B+12);
        tbl[16] = mk(1'b0, 1'b0, 64'h0,  1'b1, 1'b1, B+16,   1'b1, B+16);
        tbl[17] = mk(1'b0, 1'b0, 64'h0,  1'b0, 1'b1, B+16,   1'b0, 64'h0);

        // Reset values
        doReset();
        checkOutput("reset_req_valid", 64'(mem_req_valid), 64'h0);
        checkOutput("reset_req_addr",  mem_req_addr,       B);
        checkOutput("reset_inst_valid", 64'(inst_valid),   64'h0);
        checkOutput("reset_inst_pc",   inst_pc,            64'h0);
        checkOutput("reset_inst",      64'(inst),          64'h0);

        // Free-run fill until full, then drain with decode backpressure released
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].rdy, tbl[i].rsp, tbl[i].raddr, tbl[i].irdy, 1'b0, 1'b0, 64'h0);
            checkOutput($sformatf("t%0d_req_valid", i), 64'(mem_req_valid), 64'(tbl[i].expRv));
            checkOutput($sformatf("t%0d_req_addr", i), mem_req_addr, tbl[i].expAddr);
            checkOutput($sformatf("t%0d_inst_valid", i), 64'(inst_valid), 64'(tbl[i].expIv));
            if (tbl[i].expIv) begin
                checkOutput($sformatf("t%0d_inst_pc", i), inst_pc, tbl[i].expIpc);
                checkOutput($sformatf("t%0d_inst", i), 64'(inst), 64'(instAt(tbl[i].expIpc)));
            end
        end

        // Redirect mid-wait with a 3-cycle response
        doReset();
        acceptCycle();
        checkOutput("rw_req", 64'(mem_req_valid), 64'h1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, B + 64'h107);
        idleCycle();
        checkOutput("rw_discard_noreq", 64'(mem_req_valid), 64'h0);
        checkOutput("rw_discard_addr", mem_req_addr, B + 64'h100);
        applyStimulus(1'b0, 1'b1, B, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("rw_stale_hidden", 64'(inst_valid), 64'h0);
        acceptCycle();
        checkOutput("rw_new_req", 64'(mem_req_valid), 64'h1);
        checkOutput("rw_new_addr", mem_req_addr, B + 64'h100);
        checkOutput("rw_queue_empty", 64'(inst_valid), 64'h0);
        applyStimulus(1'b0, 1'b1, B + 64'h100, 1'b0, 1'b0, 1'b0, 64'h0);
        idleCycle();
        checkOutput("rw_inst_valid", 64'(inst_valid), 64'h1);
        checkOutput("rw_inst_pc", inst_pc, B + 64'h104);
        checkOutput("rw_inst_hi", 64'(inst), 64'(instAt(B + 64'h104)));

        // Redirect, response and pop in the same cycle
        doReset();
        acceptCycle();
        applyStimulus(1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 64'h0);
        acceptCycle();
        checkOutput("rp_head_pc", inst_pc, B);
        applyStimulus(1'b0, 1'b1, B, 1'b1, 1'b0, 1'b1, B + 64'h200);
        checkOutput("rp_pop_valid", 64'(inst_valid), 64'h1);
        checkOutput("rp_pop_pc", inst_pc, B);
        checkOutput("rp_pop_inst", 64'(inst), 64'(instAt(B)));
        idleCycle();
        checkOutput("rp_flushed", 64'(inst_valid), 64'h0);
        checkOutput("rp_req", 64'(mem_req_valid), 64'h1);
        checkOutput("rp_addr", mem_req_addr, B + 64'h200);
        acceptCycle();
        applyStimulus(1'b0, 1'b1, B + 64'h200, 1'b0, 1'b0, 1'b0, 64'h0);
        idleCycle();
        checkOutput("rp_target_pc", inst_pc, B + 64'h200);
        checkOutput("rp_target_inst", 64'(inst), 64'(instAt(B + 64'h200)));

        // Halt while waiting: the outstanding response still lands, nothing new issues
        doReset();
        acceptCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b1, B, 1'b0, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
            checkOutput($sformatf("h%0d_no_req", i), 64'(mem_req_valid), 64'h0);
        end
        checkOutput("h_enqueued_pc", inst_pc, B);
        checkOutput("h_enqueued_valid", 64'(inst_valid), 64'h1);
        idleCycle();
        idleCycle();
        checkOutput("h_resume_req", 64'(mem_req_valid), 64'h1);
        checkOutput("h_resume_addr", mem_req_addr, B);

        // Empty queue, decode ready, response arrives: bypass forwards and consumes it
        doReset();
        acceptCycle();
        applyStimulus(1'b0, 1'b1, B, 1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("bp_same_cycle_valid", 64'(inst_valid), 64'(BYP));
        checkOutput("bp_same_cycle_pc", inst_pc, BYP ? B : 64'h0);
        checkOutput("bp_same_cycle_inst", 64'(inst), BYP ? 64'(instAt(B)) : 64'h0);
        idleCycle();
        checkOutput("bp_next_valid", 64'(inst_valid), 64'(!BYP));
        checkOutput("bp_next_req", 64'(mem_req_valid), 64'h1);

        // Randomized run against the instruction-stream model
        doReset();
        pend      = 1'b0;
        pdelay    = 0;
        paddr     = 64'h0;
        expPc     = B;
        prevRv    = 1'b0;
        prevHalt  = 1'b0;
        hlt       = 1'b0;
        delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            rspNow = pend && (pdelay == 0);
            if (pend && !rspNow) pdelay--;
            if (rspNow) pend = 1'b0;
            if ($urandom_range(0, 15) == 0) hlt = !hlt;
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = rspNow;
            mem_resp_data  = rspNow ? memWord(paddr) : {$urandom, $urandom};
            inst_ready     = ($urandom_range(0, 1) == 1);
            halt           = hlt;
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = B + 64'($urandom_range(0, 1023));
            #1;
            if (mem_req_valid && !prevRv) checkOutput("rnd_halt_blocks_issue", 64'(prevHalt), 64'h0);
            if (inst_valid && inst_ready) begin
                checkOutput("rnd_stream_pc", inst_pc, expPc);
                checkOutput("rnd_stream_inst", 64'(inst), 64'(instAt(expPc)));
                expPc = expPc + 64'd4;
                delivered++;
            end
            if (redirect_valid) expPc = {redirect_pc[63:2], 2'b00};
            if (mem_req_valid && mem_req_ready) begin
                checkOutput("rnd_one_outstanding", 64'(pend), 64'h0);
                pend   = 1'b1;
                paddr  = mem_req_addr;
                pdelay = $urandom_range(0, 2);
            end
            prevRv   = mem_req_valid;
            prevHalt = halt;
        end
        checkOutput("rnd_progress", 64'(delivered >= 100), 64'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
